// File: rtl/hatch_ctrl_param.sv
// hatch_ctrl_param
// Egg-incubation controller. Owns the 1 s tick prescaler, the phase and
// frame sequencing, cold-exposure supervision and the elapsed-seconds count.
// Display logic lives elsewhere and only consumes the status outputs here.
//
// Optional feature macro: HATCH_COLD_RECOVER_EN
//   defined   -> a warm tick in SENSITIVE clears cold_cnt, so a failure needs
//                FAIL_SECS consecutive cold ticks.
//   undefined -> cold_cnt accumulates over the whole SENSITIVE phase.

module hatch_ctrl_param #(
   parameter int TICK_DIV     = 50_000_000,
   parameter int FRAME_SECS   = 2,
   parameter int SENS_FRAMES  = 10,
   parameter int TOTAL_FRAMES = 16,
   parameter int FAIL_SECS    = 5,
   parameter int FRAME_W      = 5,
   parameter int ELAP_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               start,
   input  logic               heat,
   output logic [2:0]         state,
   output logic [FRAME_W-1:0] frame,
   output logic [ELAP_W-1:0]  elapsed,
   output logic [FRAME_W-1:0] cold_cnt,
   output logic               tick,
   output logic               busy,
   output logic               done,
   output logic               fail
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam int SEC_W = $clog2(FRAME_SECS + 1);

   localparam logic [PRE_W-1:0]   PRE_MAX    = PRE_W'(TICK_DIV - 1);
   localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(FRAME_SECS);
   localparam logic [FRAME_W-1:0] SENS_LAST  = FRAME_W'(SENS_FRAMES);
   localparam logic [FRAME_W-1:0] TOTAL_LAST = FRAME_W'(TOTAL_FRAMES);
   localparam logic [FRAME_W-1:0] FAIL_LAST  = FRAME_W'(FAIL_SECS);

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_READY     = 3'd1,
      ST_SENSITIVE = 3'd2,
      ST_ROBUST    = 3'd3,
      ST_HATCHED   = 3'd4,
      ST_FAILED    = 3'd5
   } state_t;

   state_t             cur_state, nxt_state;
   logic [PRE_W-1:0]   presc,     nxt_presc;
   logic [SEC_W-1:0]   sec_cnt,   nxt_sec_cnt;
   logic [FRAME_W-1:0] frame_q,   nxt_frame;
   logic [ELAP_W-1:0]  elap_q,    nxt_elap;
   logic [FRAME_W-1:0] cold_q,    nxt_cold;

   logic               running;
   logic               tick_now;
   logic [SEC_W-1:0]   sec_inc;
   logic [FRAME_W-1:0] frame_inc;
   logic [FRAME_W-1:0] cold_inc;
   logic [ELAP_W-1:0]  elap_sat;

   // Running-phase decode and the derived increment values used below.
   always_comb begin
      running   = (cur_state == ST_SENSITIVE) || (cur_state == ST_ROBUST);
      tick_now  = running && (presc == PRE_MAX);
      sec_inc   = sec_cnt + 1'b1;
      frame_inc = frame_q + 1'b1;
      cold_inc  = cold_q + 1'b1;
      elap_sat  = (elap_q == {ELAP_W{1'b1}}) ? elap_q : elap_q + 1'b1;
   end

   // Next-state and next-counter logic; en low overrides everything else.
   always_comb begin
      nxt_state   = cur_state;
      nxt_presc   = presc;
      nxt_sec_cnt = sec_cnt;
      nxt_frame   = frame_q;
      nxt_elap    = elap_q;
      nxt_cold    = cold_q;

      if (running) begin
         nxt_presc = tick_now ? '0 : presc + 1'b1;
      end

      case (cur_state)
         ST_OFF: begin
            nxt_state = ST_READY;
         end

         ST_READY: begin
            if (start) begin
               nxt_state   = ST_SENSITIVE;
               nxt_presc   = '0;
               nxt_sec_cnt = '0;
               nxt_frame   = '0;
               nxt_elap    = '0;
               nxt_cold    = '0;
            end
         end

         ST_SENSITIVE: begin
            if (tick_now) begin
               nxt_elap = elap_sat;
               if (heat) begin
`ifdef HATCH_COLD_RECOVER_EN
                  nxt_cold = '0;
`endif
                  if (sec_inc == SEC_LAST) begin
                     nxt_sec_cnt = '0;
                     nxt_frame   = frame_inc;
                     if (frame_inc == SENS_LAST) begin
                        nxt_state = ST_ROBUST;
                     end
                  end else begin
                     nxt_sec_cnt = sec_inc;
                  end
               end else begin
                  nxt_cold = cold_inc;
                  if (cold_inc == FAIL_LAST) begin
                     nxt_state = ST_FAILED;
                  end
               end
            end
         end

         ST_ROBUST: begin
            if (tick_now) begin
               nxt_elap = elap_sat;
               if (sec_inc == SEC_LAST) begin
                  nxt_sec_cnt = '0;
                  nxt_frame   = frame_inc;
                  if (frame_inc == TOTAL_LAST) begin
                     nxt_state = ST_HATCHED;
                  end
               end else begin
                  nxt_sec_cnt = sec_inc;
               end
            end
         end

         ST_HATCHED, ST_FAILED: begin
            if (start) begin
               nxt_state = ST_READY;
            end
         end

         default: begin
            nxt_state = ST_OFF;
         end
      endcase

      if (!en) begin
         nxt_state   = ST_OFF;
         nxt_presc   = '0;
         nxt_sec_cnt = '0;
         nxt_frame   = '0;
         nxt_elap    = '0;
         nxt_cold    = '0;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= ST_OFF;
         presc     <= '0;
         sec_cnt   <= '0;
         frame_q   <= '0;
         elap_q    <= '0;
         cold_q    <= '0;
      end else begin
         cur_state <= nxt_state;
         presc     <= nxt_presc;
         sec_cnt   <= nxt_sec_cnt;
         frame_q   <= nxt_frame;
         elap_q    <= nxt_elap;
         cold_q    <= nxt_cold;
      end
   end

   // Status outputs, all taken from registered state.
   always_comb begin
      state    = cur_state;
      frame    = frame_q;
      elapsed  = elap_q;
      cold_cnt = cold_q;
      tick     = tick_now;
      busy     = running;
      done     = (cur_state == ST_HATCHED);
      fail     = (cur_state == ST_FAILED);
   end

endmodule

// File: tb/tb_hatch_ctrl_param.sv
// tb_hatch_ctrl_param
// Directed bench for hatch_ctrl_param with TICK_DIV=4, FRAME_SECS=2,
// SENS_FRAMES=10, TOTAL_FRAMES=16, FAIL_SECS=5. A second instance with a
// 4-bit elapsed counter shares the stimulus to show saturation.
// Honours HATCH_COLD_RECOVER_EN when it is defined for the build.

module tb_hatch_ctrl_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       start;
   logic       heat;

   logic [2:0] state;
   logic [4:0] frame;
   logic [7:0] elapsed;
   logic [4:0] cold_cnt;
   logic       tick;
   logic       busy;
   logic       done;
   logic       fail;

   logic [2:0] s_state;
   logic [4:0] s_frame;
   logic [3:0] s_elapsed;
   logic [4:0] s_cold_cnt;
   logic       s_tick;
   logic       s_busy;
   logic       s_done;
   logic       s_fail;

   int n_checks = 0;
   int n_fail   = 0;

   hatch_ctrl_param #(
      .TICK_DIV(4), .FRAME_SECS(2), .SENS_FRAMES(10), .TOTAL_FRAMES(16),
      .FAIL_SECS(5), .FRAME_W(5), .ELAP_W(8)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .heat(heat),
      .state(state), .frame(frame), .elapsed(elapsed), .cold_cnt(cold_cnt),
      .tick(tick), .busy(busy), .done(done), .fail(fail)
   );

   hatch_ctrl_param #(
      .TICK_DIV(4), .FRAME_SECS(2), .SENS_FRAMES(10), .TOTAL_FRAMES(16),
      .FAIL_SECS(5), .FRAME_W(5), .ELAP_W(4)
   ) dut_sat (
      .clk(clk), .rst(rst), .en(en), .start(start), .heat(heat),
      .state(s_state), .frame(s_frame), .elapsed(s_elapsed), .cold_cnt(s_cold_cnt),
      .tick(s_tick), .busy(s_busy), .done(s_done), .fail(s_fail)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycles(1);
      start = 1'b0;
   endtask

   task automatic go_ready();
      en = 1'b0;
      cycles(1);
      en = 1'b1;
      cycles(1);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; start = 1'b0; heat = 1'b0;
      cycles(2);
      n_checks++;
      if ({state, frame, elapsed, cold_cnt, tick, busy, done, fail} !== 25'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {state, frame, elapsed, cold_cnt, tick, busy, done, fail});
      end
      rst = 1'b0;
      heat = 1'b1;
      pulse_start();
      cycles(1);
      n_checks++;
      if (state !== 3'd0) begin
         n_fail++;
         $display("[TB] FAIL off_ignores_start: state %0d expected 0", state);
      end
      en = 1'b1;
      #1;
      n_checks++;
      if (state !== 3'd0) begin
         n_fail++;
         $display("[TB] FAIL off_before_edge: state %0d expected 0", state);
      end
      cycles(1);
      n_checks++;
      if ({state, frame, elapsed, cold_cnt, tick, busy, done, fail} !== {3'd1, 22'd0}) begin
         n_fail++;
         $display("[TB] FAIL ready_after_en: got %h expected %h",
                  {state, frame, elapsed, cold_cnt, tick, busy, done, fail}, {3'd1, 22'd0});
      end
   endtask

   task automatic test_full_hatch();
      go_ready();
      heat = 1'b1;
      pulse_start();
      n_checks++;
      if ({state, frame, tick, busy} !== {3'd2, 5'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL sens_entry: state %0d frame %0d tick %0d busy %0d expected 2 0 0 1",
                  state, frame, tick, busy);
      end
      cycles(3);
      n_checks++;
      if (tick !== 1'b1 || elapsed !== 8'd0) begin
         n_fail++;
         $display("[TB] FAIL first_tick: tick %0d elapsed %0d expected 1 0", tick, elapsed);
      end
      cycles(1);
      n_checks++;
      if (tick !== 1'b0 || elapsed !== 8'd1) begin
         n_fail++;
         $display("[TB] FAIL after_first_tick: tick %0d elapsed %0d expected 0 1", tick, elapsed);
      end
      pulse_start();
      cycles(74);
      n_checks++;
      if (state !== 3'd2 || frame !== 5'd9) begin
         n_fail++;
         $display("[TB] FAIL before_robust: state %0d frame %0d expected 2 9", state, frame);
      end
      cycles(1);
      n_checks++;
      if (state !== 3'd3 || frame !== 5'd10 || elapsed !== 8'd20) begin
         n_fail++;
         $display("[TB] FAIL robust_entry: state %0d frame %0d elapsed %0d expected 3 10 20",
                  state, frame, elapsed);
      end
      cycles(47);
      n_checks++;
      if (state !== 3'd3 || frame !== 5'd15) begin
         n_fail++;
         $display("[TB] FAIL before_hatch: state %0d frame %0d expected 3 15", state, frame);
      end
      cycles(1);
      n_checks++;
      if ({state, frame, elapsed, done, busy, fail} !== {3'd4, 5'd16, 8'd32, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL hatched: state %0d frame %0d elapsed %0d done %0d busy %0d fail %0d expected 4 16 32 1 0 0",
                  state, frame, elapsed, done, busy, fail);
      end
      n_checks++;
      if (s_elapsed !== 4'hF || s_state !== 3'd4) begin
         n_fail++;
         $display("[TB] FAIL elapsed_saturate: elapsed %0d state %0d expected 15 4", s_elapsed, s_state);
      end
      cycles(10);
      n_checks++;
      if (frame !== 5'd16 || elapsed !== 8'd32 || tick !== 1'b0 || done !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL hatched_frozen: frame %0d elapsed %0d tick %0d done %0d expected 16 32 0 1",
                  frame, elapsed, tick, done);
      end
      pulse_start();
      n_checks++;
      if (state !== 3'd1 || frame !== 5'd16 || elapsed !== 8'd32 || done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL hatched_ack: state %0d frame %0d elapsed %0d done %0d expected 1 16 32 0",
                  state, frame, elapsed, done);
      end
   endtask

   task automatic test_cold_fail();
      go_ready();
      heat = 1'b0;
      pulse_start();
      cycles(19);
      n_checks++;
      if (state !== 3'd2 || cold_cnt !== 5'd4) begin
         n_fail++;
         $display("[TB] FAIL before_fail: state %0d cold_cnt %0d expected 2 4", state, cold_cnt);
      end
      cycles(1);
      n_checks++;
      if ({state, cold_cnt, frame, elapsed, fail, busy} !== {3'd5, 5'd5, 5'd0, 8'd5, 1'b1, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL cold_failed: state %0d cold_cnt %0d frame %0d elapsed %0d fail %0d busy %0d expected 5 5 0 5 1 0",
                  state, cold_cnt, frame, elapsed, fail, busy);
      end
      cycles(8);
      n_checks++;
      if (tick !== 1'b0 || elapsed !== 8'd5 || state !== 3'd5) begin
         n_fail++;
         $display("[TB] FAIL failed_frozen: tick %0d elapsed %0d state %0d expected 0 5 5", tick, elapsed, state);
      end
   endtask

   task automatic test_cold_recover();
      go_ready();
      pulse_start();
      for (int k = 1; k <= 9; k++) begin
         heat = (k == 5);
         cycles(4);
         if (k == 5) begin
            n_checks++;
`ifdef HATCH_COLD_RECOVER_EN
            if (state !== 3'd2 || cold_cnt !== 5'd0) begin
               n_fail++;
               $display("[TB] FAIL warm_tick5: state %0d cold_cnt %0d expected 2 0", state, cold_cnt);
            end
`else
            if (state !== 3'd2 || cold_cnt !== 5'd4) begin
               n_fail++;
               $display("[TB] FAIL warm_tick5: state %0d cold_cnt %0d expected 2 4", state, cold_cnt);
            end
`endif
         end
         if (k == 6) begin
            n_checks++;
`ifdef HATCH_COLD_RECOVER_EN
            if (state !== 3'd2 || cold_cnt !== 5'd1) begin
               n_fail++;
               $display("[TB] FAIL cold_tick6: state %0d cold_cnt %0d expected 2 1", state, cold_cnt);
            end
`else
            if (state !== 3'd5 || cold_cnt !== 5'd5 || elapsed !== 8'd6) begin
               n_fail++;
               $display("[TB] FAIL cold_tick6: state %0d cold_cnt %0d elapsed %0d expected 5 5 6",
                        state, cold_cnt, elapsed);
            end
`endif
         end
      end
      n_checks++;
`ifdef HATCH_COLD_RECOVER_EN
      if (state !== 3'd2 || cold_cnt !== 5'd4 || elapsed !== 8'd9 || frame !== 5'd0) begin
         n_fail++;
         $display("[TB] FAIL recover_end: state %0d cold_cnt %0d elapsed %0d frame %0d expected 2 4 9 0",
                  state, cold_cnt, elapsed, frame);
      end
`else
      if (state !== 3'd5 || cold_cnt !== 5'd5 || elapsed !== 8'd6 || frame !== 5'd0) begin
         n_fail++;
         $display("[TB] FAIL recover_end: state %0d cold_cnt %0d elapsed %0d frame %0d expected 5 5 6 0",
                  state, cold_cnt, elapsed, frame);
      end
`endif
   endtask

   task automatic test_en_drop();
      go_ready();
      heat = 1'b1;
      pulse_start();
      cycles(96);
      n_checks++;
      if (state !== 3'd3 || frame !== 5'd12 || elapsed !== 8'd24) begin
         n_fail++;
         $display("[TB] FAIL robust_frame12: state %0d frame %0d elapsed %0d expected 3 12 24",
                  state, frame, elapsed);
      end
      en = 1'b0;
      cycles(1);
      n_checks++;
      if ({state, frame, elapsed, cold_cnt, busy, tick} !== 23'd0) begin
         n_fail++;
         $display("[TB] FAIL en_drop_off: state %0d frame %0d elapsed %0d cold_cnt %0d busy %0d tick %0d expected all 0",
                  state, frame, elapsed, cold_cnt, busy, tick);
      end
      en = 1'b1;
      cycles(1);
      n_checks++;
      if (state !== 3'd1 || frame !== 5'd0) begin
         n_fail++;
         $display("[TB] FAIL en_back_ready: state %0d frame %0d expected 1 0", state, frame);
      end
      pulse_start();
      cycles(8);
      n_checks++;
      if (state !== 3'd2 || frame !== 5'd1 || elapsed !== 8'd2) begin
         n_fail++;
         $display("[TB] FAIL restart_fresh: state %0d frame %0d elapsed %0d expected 2 1 2",
                  state, frame, elapsed);
      end
   endtask

   task automatic test_edge_cases();
      go_ready();
      heat = 1'b1;
      pulse_start();
      cycles(4);
      heat = 1'b0;
      cycles(4);
      n_checks++;
      if (state !== 3'd2 || frame !== 5'd0 || cold_cnt !== 5'd1 || elapsed !== 8'd2) begin
         n_fail++;
         $display("[TB] FAIL cold_on_advance: state %0d frame %0d cold_cnt %0d elapsed %0d expected 2 0 1 2",
                  state, frame, cold_cnt, elapsed);
      end
      heat = 1'b1;
      cycles(76);
      n_checks++;
      if (state !== 3'd3 || frame !== 5'd10) begin
         n_fail++;
         $display("[TB] FAIL delayed_robust: state %0d frame %0d expected 3 10", state, frame);
      end
      heat = 1'b0;
      cycles(8);
      n_checks++;
`ifdef HATCH_COLD_RECOVER_EN
      if (state !== 3'd3 || frame !== 5'd11 || cold_cnt !== 5'd0 || elapsed !== 8'd23) begin
         n_fail++;
         $display("[TB] FAIL robust_cold_advance: state %0d frame %0d cold_cnt %0d elapsed %0d expected 3 11 0 23",
                  state, frame, cold_cnt, elapsed);
      end
`else
      if (state !== 3'd3 || frame !== 5'd11 || cold_cnt !== 5'd1 || elapsed !== 8'd23) begin
         n_fail++;
         $display("[TB] FAIL robust_cold_advance: state %0d frame %0d cold_cnt %0d elapsed %0d expected 3 11 1 23",
                  state, frame, cold_cnt, elapsed);
      end
`endif
   endtask

   // Runs every scenario in order and prints the summary.
   initial begin
      rst = 1'b1; en = 1'b0; start = 1'b0; heat = 1'b0;
      $display("[TB] starting hatch_ctrl_param bench");
      test_reset();
      test_full_hatch();
      test_cold_fail();
      test_cold_recover();
      test_en_drop();
      test_edge_cases();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
